// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer
// Purpose  : Multicycle fetch/decode/execute controller. Owns the PC and IR,
//            issues register-file and data-memory strobes and resolves branches.
// Revision : 1.0 - initial release
// ============================================================================
module core_sequencer #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    input  logic            dec_load_en,
    input  logic            dec_write_en,
    input  logic            dec_data_sel,
    input  logic            dec_j,
    input  logic [1:0]      dec_bsel,
    input  logic [15:0]     dec_im_offset,
    input  logic            a_zero,
    input  logic [PC_W-1:0] a_value,
    output logic            rf_we,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_FWAIT  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [4:0] c_first_illegal_op = 5'd22;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic            r_imem_req;
    logic            r_rf_we;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic            r_halted;
    logic            r_illegal;

    logic [31:0]     w_off_ext;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_rel_target;
    logic [PC_W-1:0] w_branch_pc;
    logic            w_taken;
    logic            w_alu;
    logic            w_ir_illegal;

    // Offsets are relative to the branch's own address; PC_W is assumed <= 32.
    assign w_off_ext    = {{16{dec_im_offset[15]}}, dec_im_offset};
    assign w_pc_inc     = r_pc + PC_W'(1);
    assign w_rel_target = r_pc + w_off_ext[PC_W-1:0];
    assign w_alu        = dec_load_en & ~dec_data_sel;
    assign w_ir_illegal = (r_ir[31:27] >= c_first_illegal_op);

    always_comb begin
        w_taken = 1'b1;
        case (dec_bsel)
            2'b00:   w_taken = a_zero;
            2'b01:   w_taken = ~a_zero;
            default: w_taken = 1'b1;
        endcase
    end

    always_comb begin
        w_branch_pc = w_pc_inc;
        if (w_taken)
            w_branch_pc = (dec_bsel == 2'b11) ? a_value : w_rel_target;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= '0;
            r_imem_req <= 1'b0;
            r_rf_we    <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (run) begin
                        r_imem_req <= 1'b1;
                        r_state    <= S_FWAIT;
                    end
                end
                S_FWAIT: begin
                    if (imem_ack) begin
                        r_ir       <= imem_rdata;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_ir_illegal) begin
                        r_illegal <= 1'b1;
                        r_halted  <= 1'b1;
                        r_state   <= S_HALT;
                    end else begin
                        // Decoder outputs are already stable here, so the ALU
                        // write strobe can be registered to coincide with EXEC.
                        r_rf_we <= w_alu;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_alu) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                    end else if (dec_data_sel || dec_write_en) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= ~dec_data_sel;
                        r_state    <= S_MEM;
                    end else if (dec_j) begin
                        r_pc    <= w_branch_pc;
                        r_state <= S_FETCH;
                    end else begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        // Load data is written back in the cycle after the ack.
                        r_rf_we    <= ~r_dmem_we;
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_pc       <= w_pc_inc;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign ir        = r_ir;
    assign rf_we     = r_rf_we;
    assign dmem_req  = r_dmem_req;
    assign dmem_we   = r_dmem_we;
    assign pc        = r_pc;
    assign halted    = r_halted;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_sequencer
// Purpose  : Directed and randomized instruction stream against a PC/latency
//            reference model for core_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_NOP = 3,
                   K_BZ = 4, K_BNZ = 5, K_JMP = 6, K_JMR = 7, K_ILL = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] ir;
    logic        dec_load_en = 1'b0, dec_write_en = 1'b0, dec_data_sel = 1'b0, dec_j = 1'b0;
    logic [1:0]  dec_bsel = '0;
    logic [15:0] dec_im_offset = '0;
    logic        a_zero = 1'b0;
    logic [15:0] a_value = '0;
    logic        rf_we, dmem_req, dmem_we;
    logic        dmem_ack = 1'b0;
    logic [15:0] pc;
    logic        halted, illegal;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] m_pc;

    core_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir),
        .dec_load_en(dec_load_en), .dec_write_en(dec_write_en),
        .dec_data_sel(dec_data_sel), .dec_j(dec_j), .dec_bsel(dec_bsel),
        .dec_im_offset(dec_im_offset), .a_zero(a_zero), .a_value(a_value),
        .rf_we(rf_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc(pc), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule, computed with plain integer arithmetic.
    function automatic logic [15:0] model_next_pc(input int kind, input logic [15:0] cur,
                                                  input logic [15:0] off, input logic az,
                                                  input logic [15:0] aval);
        int soff, t;
        bit taken;
        soff  = (off >= 16'h8000) ? int'(off) - 65536 : int'(off);
        taken = (kind == K_JMP) || (kind == K_JMR) ||
                (kind == K_BZ && az) || (kind == K_BNZ && !az);
        if (kind == K_ILL)      t = int'(cur);
        else if (!taken)        t = int'(cur) + 1;
        else if (kind == K_JMR) t = int'(aval);
        else                    t = int'(cur) + soff;
        return 16'(t & 32'hFFFF);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #2;
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_ir", ir, 0);
        chk("rst_strobes", {29'd0, rf_we, dmem_req, dmem_we}, 0);
        chk("rst_halt_ill", {30'd0, halted, illegal}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_pc  = 16'h0000;
    endtask

    task automatic exec_instr(input int kind, input logic [31:0] word, input logic [15:0] off,
                              input logic az, input logic [15:0] aval, input int iw, input int dw);
        int lat, n_cyc, ireq_n, dreq_n, dwe_n, rf_n, rf_at, halt_at, ovl, dbl;
        int exp_rf_at, exp_dreq;
        bit is_mem, prev_rf;
        logic [15:0] exp_pc, pc_before, pc_after;

        is_mem = (kind == K_LD) || (kind == K_ST);
        exp_pc = model_next_pc(kind, m_pc, off, az, aval);
        if (kind == K_ILL) lat = 3 + iw;
        else if (is_mem)   lat = 5 + iw + dw;
        else               lat = 4 + iw;
        exp_rf_at = (kind == K_ALU) ? 3 + iw : (kind == K_LD) ? lat : -1;
        exp_dreq  = is_mem ? dw + 1 : 0;
        n_cyc     = lat + 4;

        @(negedge clk);
        dec_load_en   = (kind == K_ALU) || (kind == K_LD);
        dec_data_sel  = (kind == K_LD);
        dec_write_en  = (kind == K_ST);
        dec_j         = (kind >= K_BZ) && (kind <= K_JMR);
        dec_bsel      = (kind == K_BNZ) ? 2'b01 : (kind == K_JMP) ? 2'b10 :
                        (kind == K_JMR) ? 2'b11 : 2'b00;
        dec_im_offset = off;
        a_zero        = az;
        a_value       = aval;
        imem_rdata    = word;
        run           = 1'b1;
        chk("start_pc", 32'(pc), 32'(m_pc));

        ireq_n = 0; dreq_n = 0; dwe_n = 0; rf_n = 0; rf_at = -1; halt_at = -1;
        ovl = 0; dbl = 0; prev_rf = 1'b0; pc_before = 'x; pc_after = 'x;
        for (int cyc = 1; cyc <= n_cyc; cyc++) begin
            @(negedge clk);
            run = 1'b0;
            if (imem_req) ireq_n++;
            if (dmem_req) dreq_n++;
            if (dmem_req && dmem_we) dwe_n++;
            if (imem_req && dmem_req) ovl++;
            if (rf_we) begin
                rf_n++;
                if (rf_at < 0) rf_at = cyc;
                if (prev_rf) dbl++;
            end
            if (halted && halt_at < 0) halt_at = cyc;
            prev_rf = rf_we;
            if (cyc == lat - 1) pc_before = pc;
            if (cyc == lat)     pc_after  = pc;
            imem_ack = imem_req && (ireq_n == iw + 1);
            dmem_ack = dmem_req && (dreq_n == dw + 1);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        chk("imem_req_cycles", ireq_n, iw + 1);
        chk("ir", ir, word);
        chk("rf_we_pulses", rf_n, (kind == K_ALU || kind == K_LD) ? 1 : 0);
        chk("rf_we_cycle", rf_at, exp_rf_at);
        chk("rf_we_back_to_back", dbl, 0);
        chk("dmem_req_cycles", dreq_n, exp_dreq);
        chk("dmem_we_cycles", dwe_n, (kind == K_ST) ? dw + 1 : 0);
        chk("req_overlap", ovl, 0);
        chk("halt_cycle", halt_at, (kind == K_ILL) ? 3 + iw : -1);
        chk("illegal_flag", 32'(illegal), (kind == K_ILL) ? 1 : 0);
        chk("pc_held_until_done", 32'(pc_before), 32'(m_pc));
        chk("pc_next", 32'(pc_after), 32'(exp_pc));
        chk("pc_final", 32'(pc), 32'(exp_pc));
        m_pc = exp_pc;
    endtask

    initial begin
        int kind, iw, dw;
        logic [31:0] word;
        logic [15:0] off, aval;
        logic [4:0]  op;
        logic        az;

        do_reset();

        // run gating: no fetch while run stays low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_imem_req", 32'(imem_req), 0);
            chk("idle_pc", 32'(pc), 0);
        end

        exec_instr(K_ALU, 32'h10800008, 16'h0000, 1'b0, 16'h0000, 2, 0);
        exec_instr(K_LD,  32'h08400002, 16'h0000, 1'b0, 16'h0000, 0, 3);
        exec_instr(K_NOP, 32'h00000000, 16'h0000, 1'b0, 16'h0000, 0, 0);
        exec_instr(K_NOP, 32'h00000000, 16'h0000, 1'b0, 16'h0000, 1, 0);
        exec_instr(K_NOP, 32'h00000000, 16'h0000, 1'b0, 16'h0000, 0, 0);
        exec_instr(K_ST,  32'h18400003, 16'h0000, 1'b0, 16'h0000, 0, 2);

        exec_instr(K_JMR, 32'hA8000000, 16'h0000, 1'b0, 16'h0010, 0, 0);
        exec_instr(K_BZ,  32'h98000000, 16'hFFFC, 1'b1, 16'h0000, 0, 0);
        exec_instr(K_JMR, 32'hA8000000, 16'h0000, 1'b0, 16'h0010, 0, 0);
        exec_instr(K_BZ,  32'h98000000, 16'hFFFC, 1'b0, 16'h0000, 1, 0);
        exec_instr(K_JMR, 32'hA8000000, 16'h0000, 1'b0, 16'h0010, 0, 0);
        exec_instr(K_BNZ, 32'h98000000, 16'hFFFC, 1'b0, 16'h0000, 0, 0);
        exec_instr(K_JMR, 32'hA8000000, 16'h0000, 1'b0, 16'h0010, 0, 0);
        exec_instr(K_JMR, 32'hA8000000, 16'h0000, 1'b0, 16'h1234, 0, 0);

        exec_instr(K_JMR, 32'hA8000000, 16'h0000, 1'b0, 16'hFFFF, 0, 0);
        exec_instr(K_JMP, 32'hA0000000, 16'h0000, 1'b0, 16'h0000, 0, 0);
        exec_instr(K_NOP, 32'h00000000, 16'h0000, 1'b0, 16'h0000, 0, 0);

        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 7));
            op   = 5'($urandom_range(0, 21));
            word = {op, 27'($urandom)};
            off  = 16'($urandom);
            aval = 16'($urandom);
            az   = 1'($urandom);
            iw   = int'($urandom_range(0, 3));
            dw   = int'($urandom_range(0, 3));
            exec_instr(kind, word, off, az, aval, iw, dw);
        end

        // Illegal opcode halts for good; the trailing idle cycles see no strobes.
        exec_instr(K_ILL, 32'hF8000000, 16'h0000, 1'b0, 16'h0000, 1, 0);
        @(negedge clk);
        run = 1'b1;
        repeat (4) @(negedge clk);
        chk("halt_no_fetch", 32'(imem_req), 0);
        chk("halt_pc_frozen", 32'(pc), 32'(m_pc));
        run = 1'b0;

        do_reset();

        // Reset asserted mid-FWAIT, then a stale ack after release.
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("fwait_req", 32'(imem_req), 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(imem_req), 0);
        chk("async_pc", 32'(pc), 0);
        chk("async_illegal", 32'(illegal), 0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 32'(imem_req), 0);
        chk("late_ack_ir", ir, 0);
        m_pc = 16'h0000;
        exec_instr(K_ALU, 32'h10800008, 16'h0000, 1'b0, 16'h0000, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
